// File: rtl/dl_router.sv
// Download router: steers the HPS ioctl byte stream to one of NUM_TGT memory targets.
// Define DL_CHECKSUM_EN to add the per-target 16-bit byte sum output tgt_sum.
module dl_router #(
  parameter int                   NUM_TGT   = 4,
  parameter int                   ADDR_W    = 16,
  parameter logic [NUM_TGT*6-1:0] TGT_INDEX = {6'd3, 6'd2, 6'd1, 6'd0},
  parameter logic [NUM_TGT-1:0]   RST_TGT   = 4'b0011,
  parameter int                   RST_HOLD  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ioctl_download,
  input  logic                        ioctl_wr,
  input  logic [24:0]                 ioctl_addr,
  input  logic [7:0]                  ioctl_dout,
  input  logic [7:0]                  ioctl_index,
  output logic                        ioctl_wait,
  input  logic [NUM_TGT-1:0]          tgt_busy,
  output logic [NUM_TGT-1:0]          tgt_wr,
  output logic [ADDR_W-1:0]           tgt_addr,
  output logic [7:0]                  tgt_data,
  output logic [NUM_TGT-1:0]          tgt_active,
  output logic [NUM_TGT*ADDR_W-1:0]   tgt_mask,
  output logic [NUM_TGT-1:0]          tgt_overflow,
  output logic                        sys_reset_req,
  output logic                        dl_done
`ifdef DL_CHECKSUM_EN
  ,
  output logic [NUM_TGT*16-1:0]       tgt_sum
`endif
);

  localparam int IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int CNT_W = $clog2(RST_HOLD + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STALL  = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0]        state;
  logic              dl_prev;
  logic [IDX_W-1:0]  cur;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic [CNT_W-1:0]  hold_cnt;

  logic              match_any;
  logic [IDX_W-1:0]  match_idx;
  logic              dl_rise;
  logic              start_load;
  logic              addr_ovf;
  logic [NUM_TGT-1:0] cur_onehot;
  logic [ADDR_W-1:0] new_last;
  logic              unused_index_bits;

  assign unused_index_bits = ^ioctl_index[7:6];

  // Descending scan so the lowest matching target index wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int k = NUM_TGT - 1; k >= 0; k--) begin
      if (ioctl_index[5:0] == TGT_INDEX[k*6 +: 6]) begin
        match_any = 1'b1;
        match_idx = IDX_W'(k);
      end
    end
  end

  assign dl_rise    = ioctl_download & ~dl_prev;
  assign start_load = dl_rise & match_any & ((state == S_IDLE) | (state == S_HOLD));
  assign addr_ovf   = |ioctl_addr[24:ADDR_W];
  assign cur_onehot = NUM_TGT'(1) << cur;
  assign new_last   = (ioctl_addr[ADDR_W-1:0] > last_addr) ? ioctl_addr[ADDR_W-1:0] : last_addr;

  // Sets every bit below the highest set bit, giving the smallest 2^n-1 covering the address.
  function automatic logic [ADDR_W-1:0] fill_mask(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] m;
    m = '0;
    for (int i = 0; i < ADDR_W; i++) m = m | (a >> i);
    return m;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      dl_prev       <= 1'b0;
      cur           <= '0;
      last_addr     <= '0;
      buf_addr      <= '0;
      buf_data      <= '0;
      hold_cnt      <= '0;
      ioctl_wait    <= 1'b0;
      tgt_wr        <= '0;
      tgt_addr      <= '0;
      tgt_data      <= '0;
      tgt_active    <= '0;
      tgt_mask      <= '0;
      tgt_overflow  <= '0;
      sys_reset_req <= 1'b0;
      dl_done       <= 1'b0;
`ifdef DL_CHECKSUM_EN
      tgt_sum       <= '0;
`endif
    end else begin
      dl_prev <= ioctl_download;
      tgt_wr  <= '0;
      dl_done <= 1'b0;

      if (start_load) begin
        state                   <= S_LOAD;
        cur                     <= match_idx;
        tgt_active              <= NUM_TGT'(1) << match_idx;
        last_addr               <= '0;
        tgt_overflow[match_idx] <= 1'b0;
        if (RST_TGT[match_idx]) sys_reset_req <= 1'b1;
`ifdef DL_CHECKSUM_EN
        tgt_sum[match_idx*16 +: 16] <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;

          S_LOAD: begin
            if (!ioctl_download) begin
              state <= S_FINISH;
            end else if (ioctl_wr) begin
              if (addr_ovf) begin
                tgt_overflow[cur] <= 1'b1;
              end else begin
                // The byte is committed here even if it has to wait in STALL.
                last_addr <= new_last;
`ifdef DL_CHECKSUM_EN
                tgt_sum[cur*16 +: 16] <= tgt_sum[cur*16 +: 16] + 16'(ioctl_dout);
`endif
                if (tgt_busy[cur]) begin
                  buf_addr   <= ioctl_addr[ADDR_W-1:0];
                  buf_data   <= ioctl_dout;
                  ioctl_wait <= 1'b1;
                  state      <= S_STALL;
                end else begin
                  tgt_wr   <= cur_onehot;
                  tgt_addr <= ioctl_addr[ADDR_W-1:0];
                  tgt_data <= ioctl_dout;
                end
              end
            end
          end

          S_STALL: begin
            if (!tgt_busy[cur]) begin
              tgt_wr     <= cur_onehot;
              tgt_addr   <= buf_addr;
              tgt_data   <= buf_data;
              ioctl_wait <= 1'b0;
              state      <= S_LOAD;
            end
          end

          S_FINISH: begin
            tgt_mask[cur*ADDR_W +: ADDR_W] <= fill_mask(last_addr);
            tgt_active <= '0;
            dl_done    <= 1'b1;
            hold_cnt   <= '0;
            state      <= sys_reset_req ? S_HOLD : S_IDLE;
          end

          S_HOLD: begin
            if (hold_cnt == CNT_W'(RST_HOLD - 1)) begin
              sys_reset_req <= 1'b0;
              state         <= S_IDLE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dl_router.sv
// Directed bench for dl_router: plain load with reset hold, back-pressure, no-match,
// address overflow, reset mid-download and (with DL_CHECKSUM_EN) the byte sum.
module tb_dl_router;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic [3:0]  tgt_busy;
  logic [3:0]  tgt_wr;
  logic [15:0] tgt_addr;
  logic [7:0]  tgt_data;
  logic [3:0]  tgt_active;
  logic [63:0] tgt_mask;
  logic [3:0]  tgt_overflow;
  logic        sys_reset_req;
  logic        dl_done;
`ifdef DL_CHECKSUM_EN
  logic [63:0] tgt_sum;
`endif

  int tests = 0;
  int fails = 0;
  int wr_pulses = 0;
  int wait_cycles = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  dl_router dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .tgt_busy       (tgt_busy),
    .tgt_wr         (tgt_wr),
    .tgt_addr       (tgt_addr),
    .tgt_data       (tgt_data),
    .tgt_active     (tgt_active),
    .tgt_mask       (tgt_mask),
    .tgt_overflow   (tgt_overflow),
    .sys_reset_req  (sys_reset_req),
    .dl_done        (dl_done)
`ifdef DL_CHECKSUM_EN
    ,
    .tgt_sum        (tgt_sum)
`endif
  );

  // Event counters sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (tgt_wr != 4'b0) wr_pulses++;
    if (ioctl_wait) wait_cycles++;
    if (dl_done) done_pulses++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One write strobe; checks the 1-cycle-latency pulse and its return to zero.
  task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d, input logic [3:0] exp_wr, output bit ok);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    ok = (tgt_wr === exp_wr) && ((exp_wr == 4'b0) || ((tgt_addr === a[15:0]) && (tgt_data === d)));
    @(negedge clk);
    ok = ok && (tgt_wr === 4'b0);
  endtask

  task automatic startDownload(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(negedge clk);
  endtask

  task automatic endDownload(output int done_seen, output int rst_cycles);
    done_seen  = 0;
    rst_cycles = 0;
    ioctl_download = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dl_done) begin
        done_seen = 1;
        break;
      end
    end
    for (int i = 0; i < 40; i++) begin
      if (!sys_reset_req) break;
      rst_cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    bit stall_ok;
    int bad;
    int base_wr;
    int base_wait;
    int base_done;
    int done_seen;
    int rst_cycles;
    logic [63:0] mask_before;

    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    tgt_busy       = '0;
    repeat (2) @(negedge clk);

    checkOutput("reset_ctrl", {60'h0, tgt_wr}, 64'h0);
    checkOutput("reset_flags", {56'h0, tgt_active, tgt_overflow}, 64'h0);
    checkOutput("reset_mask", tgt_mask, 64'h0);
    checkOutput("reset_misc", {37'h0, ioctl_wait, sys_reset_req, dl_done, tgt_addr, tgt_data}, 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Target 1: 0x1800 bytes, no back-pressure, reset request with hold.
    startDownload(8'd1);
    checkOutput("t1_active", {60'h0, tgt_active}, 64'h2);
    checkOutput("t1_rst_req", {63'h0, sys_reset_req}, 64'h1);
    base_wr = wr_pulses;
    base_wait = wait_cycles;
    base_done = done_pulses;
    bad = 0;
    for (int i = 0; i < 'h1800; i++) begin
      applyStimulus(25'(i), 8'(i) ^ 8'h5A, 4'b0010, ok);
      if (!ok) bad++;
    end
    checkOutput("t1_pulse_errs", 64'(bad), 64'h0);
    checkOutput("t1_pulse_count", 64'(wr_pulses - base_wr), 64'h1800);
    checkOutput("t1_no_wait", 64'(wait_cycles - base_wait), 64'h0);
    endDownload(done_seen, rst_cycles);
    checkOutput("t1_done_seen", 64'(done_seen), 64'h1);
    checkOutput("t1_rst_hold", 64'(rst_cycles), 64'd16);
    checkOutput("t1_done_count", 64'(done_pulses - base_done), 64'h1);
    checkOutput("t1_mask", {48'h0, tgt_mask[31:16]}, 64'h1FFF);
    checkOutput("t1_inactive", {60'h0, tgt_active}, 64'h0);

    // Target 2: byte 3 stalls for 5 cycles behind tgt_busy[2].
    startDownload(8'd2);
    base_wr = wr_pulses;
    base_wait = wait_cycles;
    bad = 0;
    stall_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        ioctl_addr = 25'd3;
        ioctl_dout = 8'hA3;
        ioctl_wr   = 1'b1;
        tgt_busy   = 4'b0100;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          ioctl_wr = 1'b0;
          if (tgt_wr !== 4'b0 || ioctl_wait !== 1'b1) bad++;
          if (c == 4) tgt_busy = 4'b0;
        end
        @(negedge clk);
        stall_ok = (tgt_wr === 4'b0100) && (tgt_addr === 16'd3) && (tgt_data === 8'hA3) && (ioctl_wait === 1'b0);
        @(negedge clk);
        if (tgt_wr !== 4'b0) bad++;
      end else begin
        applyStimulus(25'(i), 8'hA0 + 8'(i), 4'b0100, ok);
        if (!ok) bad++;
      end
    end
    checkOutput("t2_stall_write", {63'h0, stall_ok}, 64'h1);
    checkOutput("t2_errs", 64'(bad), 64'h0);
    checkOutput("t2_wait_cycles", 64'(wait_cycles - base_wait), 64'd5);
    checkOutput("t2_pulse_count", 64'(wr_pulses - base_wr), 64'd8);
    endDownload(done_seen, rst_cycles);
    checkOutput("t2_done_seen", 64'(done_seen), 64'h1);
    checkOutput("t2_no_rst", 64'(rst_cycles), 64'h0);
    checkOutput("t2_masks", tgt_mask, {16'h0000, 16'h0007, 16'h1FFF, 16'h0000});

    // Index 5 matches nothing: all strobes ignored.
    mask_before = tgt_mask;
    base_wr = wr_pulses;
    base_wait = wait_cycles;
    base_done = done_pulses;
    startDownload(8'h05);
    checkOutput("t3_inactive", {60'h0, tgt_active}, 64'h0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(25'(i), 8'h33, 4'b0000, ok);
      if (!ok) bad++;
    end
    endDownload(done_seen, rst_cycles);
    checkOutput("t3_errs", 64'(bad), 64'h0);
    checkOutput("t3_no_writes", 64'(wr_pulses - base_wr), 64'h0);
    checkOutput("t3_no_done", 64'(done_pulses - base_done), 64'h0);
    checkOutput("t3_no_wait", 64'(wait_cycles - base_wait), 64'h0);
    checkOutput("t3_masks", tgt_mask, mask_before);

    // Target 0: last in-range address then first out-of-range one.
    startDownload(8'd0);
    applyStimulus(25'h0FFFF, 8'h11, 4'b0001, ok);
    checkOutput("t4_top_write", {63'h0, ok}, 64'h1);
    applyStimulus(25'h10000, 8'h22, 4'b0000, ok);
    checkOutput("t4_ovf_dropped", {63'h0, ok}, 64'h1);
    checkOutput("t4_ovf_flag", {60'h0, tgt_overflow}, 64'h1);
    endDownload(done_seen, rst_cycles);
    checkOutput("t4_rst_hold", 64'(rst_cycles), 64'd16);
    checkOutput("t4_mask", {48'h0, tgt_mask[15:0]}, 64'hFFFF);
    checkOutput("t4_ovf_sticky", {60'h0, tgt_overflow}, 64'h1);

    // Target 3: reset asserted at byte 100, download continues afterwards.
    startDownload(8'd3);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(25'h200 + 25'(i), 8'(i), 4'b1000, ok);
      if (!ok) bad++;
    end
    checkOutput("t5_pre_errs", 64'(bad), 64'h0);
    ioctl_addr = 25'h264;
    ioctl_dout = 8'h64;
    ioctl_wr   = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t5_async_ctrl", {54'h0, tgt_wr, tgt_active, ioctl_wait, dl_done}, 64'h0);
    checkOutput("t5_async_state", {59'h0, tgt_overflow, sys_reset_req}, 64'h0);
    checkOutput("t5_async_mask", tgt_mask, 64'h0);
    checkOutput("t5_async_bus", {40'h0, tgt_addr, tgt_data}, 64'h0);
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("t5_reentry", {60'h0, tgt_active}, 64'h8);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(25'(i), ~8'(i), 4'b1000, ok);
      if (!ok) bad++;
    end
    checkOutput("t5_post_errs", 64'(bad), 64'h0);
    endDownload(done_seen, rst_cycles);
    checkOutput("t5_done_seen", 64'(done_seen), 64'h1);
    checkOutput("t5_masks", tgt_mask, {16'h007F, 48'h0});

`ifdef DL_CHECKSUM_EN
    // 300 bytes of 0xFF: 300*255 = 76500 -> 0x2AD4 after 16-bit wrap.
    startDownload(8'd3);
    for (int i = 0; i < 300; i++) applyStimulus(25'(i), 8'hFF, 4'b1000, ok);
    endDownload(done_seen, rst_cycles);
    checkOutput("t6_sum", {48'h0, tgt_sum[63:48]}, 64'h2AD4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
